// File: rtl/axilite_regbank.sv
// AXI4-Lite slave register bank with byte-strobed RW registers and sticky RO status
// registers (optional clear-on-read). AW and W are accepted independently into one-entry holders.
module axilite_regbank #(
  parameter int                  C_AXI_DATA_WIDTH     = 32,
  parameter int                  C_AXI_ADDR_WIDTH     = 8,
  parameter int                  NUM_REGS             = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK              = '0,
  parameter bit                  OPT_READ_SIDEEFFECTS = 1'b1
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_ARESET,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
  input  logic [2:0]                           AXI_AWPROT,
  input  logic                                 AXI_AWVALID,
  output logic                                 AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]          AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]        AXI_WSTRB,
  input  logic                                 AXI_WVALID,
  output logic                                 AXI_WREADY,
  output logic [1:0]                           AXI_BRESP,
  output logic                                 AXI_BVALID,
  input  logic                                 AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_ARADDR,
  input  logic [2:0]                           AXI_ARPROT,
  input  logic                                 AXI_ARVALID,
  output logic                                 AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]          AXI_RDATA,
  output logic [1:0]                           AXI_RRESP,
  output logic                                 AXI_RVALID,
  input  logic                                 AXI_RREADY,
  output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                  reg_wr_pulse,
  output logic [NUM_REGS-1:0]                  reg_rd_pulse
);

  localparam int DW       = C_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDX_W    = C_AXI_ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                aw_full;
  logic                w_full;
  logic [IDX_W-1:0]    aw_idx;
  logic [DW-1:0]       w_data;
  logic [SW-1:0]       w_strb;
  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                commit;
  logic [IDX_W-1:0]    ar_idx;
  logic [NUM_REGS-1:0] aw_dec;
  logic [NUM_REGS-1:0] ar_dec;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] rd_sel;
  logic                aw_ok;
  logic                aw_ro;
  logic                ar_ok;
  logic [DW-1:0]       rd_word;
  logic                unused_ok;

  assign AXI_AWREADY = !aw_full;
  assign AXI_WREADY  = !w_full;
  assign AXI_ARREADY = !AXI_RVALID || AXI_RREADY;

  assign aw_hs  = AXI_AWVALID && !aw_full;
  assign w_hs   = AXI_WVALID && !w_full;
  assign ar_hs  = AXI_ARVALID && AXI_ARREADY;
  // A held pair may only commit when the B slot is free or being drained this edge.
  assign commit = aw_full && w_full && (!AXI_BVALID || AXI_BREADY);

  assign ar_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    aw_dec = '0;
    ar_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_dec[i] = (aw_idx == IDX_W'(i));
      ar_dec[i] = (ar_idx == IDX_W'(i));
    end
  end

  // An index beyond NUM_REGS matches no decode bit, which is exactly the SLVERR case.
  assign aw_ok  = |aw_dec;
  assign aw_ro  = |(aw_dec & RO_MASK);
  assign ar_ok  = |ar_dec;
  assign wr_sel = commit ? (aw_dec & ~RO_MASK) : '0;
  assign rd_sel = ar_hs ? ar_dec : '0;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_dec[i]) rd_word = reg_out[i*DW +: DW];
    end
  end

  // Write holders: filled by their own handshake, emptied together on commit.
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= AXI_WDATA;
        w_strb <= AXI_WSTRB;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      AXI_BVALID <= 1'b0;
      AXI_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      AXI_BVALID <= 1'b1;
      AXI_BRESP  <= (aw_ok && !aw_ro) ? RESP_OKAY : RESP_SLVERR;
    end else if (AXI_BREADY) begin
      AXI_BVALID <= 1'b0;
    end
  end

  // Read data is captured from the pre-edge register value, so a same-edge write is not seen.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      AXI_RVALID <= 1'b0;
      AXI_RDATA  <= '0;
      AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      AXI_RVALID <= 1'b1;
      AXI_RDATA  <= rd_word;
      AXI_RRESP  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (AXI_RREADY) begin
      AXI_RVALID <= 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      reg_wr_pulse <= '0;
      reg_rd_pulse <= '0;
    end else begin
      reg_wr_pulse <= wr_sel;
      reg_rd_pulse <= rd_sel;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DW-1:0] value;

    if (RO_MASK[i]) begin : g_ro
      // Sticky status; a clearing read reloads from reg_in so bits arriving that cycle survive.
      always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
          value <= '0;
        end else if (OPT_READ_SIDEEFFECTS && rd_sel[i]) begin
          value <= reg_in[i*DW +: DW];
        end else begin
          value <= value | reg_in[i*DW +: DW];
        end
      end
    end else begin : g_rw
      // NOTE: the register file is reset explicitly; software relies on a known 0 after reset.
      always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
          value <= '0;
        end else if (wr_sel[i]) begin
          for (int b = 0; b < SW; b++) begin
            if (w_strb[b]) value[b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
    end

    assign reg_out[i*DW +: DW] = value;
  end

  // Protection bits, byte-offset address bits and reg_in of RW registers carry no meaning here.
  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[ADDR_LSB-1:0],
                       AXI_ARADDR[ADDR_LSB-1:0], reg_in};

endmodule
